// File: rtl/pdp8_iot_exerciser_pkg.sv
//------------------------------------------------------------------------------
// Module : pdp8_iot_pkg
// Brief  : Shared op codes, script entry layout and default IOT phase codes.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pdp8_iot_pkg;

    localparam int ENTRY_W = 44;

    localparam int F_OP_LO    = 42;
    localparam int F_CHK_SKIP = 41;
    localparam int F_EXP_SKIP = 40;
    localparam int F_CHK_AC   = 39;
    localparam int F_MB_LO    = 24;
    localparam int F_AC_LO    = 12;
    localparam int F_EXP_LO   = 0;

    // Same encodings the pdp8 CPU state decode uses for the IOT phases.
    localparam logic [3:0] C_ST_F0 = 4'h1;
    localparam logic [3:0] C_ST_F1 = 4'h2;
    localparam logic [3:0] C_ST_F2 = 4'h3;
    localparam logic [3:0] C_ST_F3 = 4'h4;

    typedef enum logic [1:0] {
        OP_IOT      = 2'b00,
        OP_WAIT_INT = 2'b01,
        OP_WAIT_CYC = 2'b10,
        OP_HALT     = 2'b11
    } op_e;

    // Executable view of an entry; the reserved bits [38:36] are not carried.
    typedef struct packed {
        op_e         op;
        logic        chk_skip;
        logic        exp_skip;
        logic        chk_ac;
        logic [11:0] mb;
        logic [11:0] ac;
        logic [11:0] exp;
    } iot_cmd_t;

    function automatic iot_cmd_t decode_entry(input logic [ENTRY_W-1:0] raw);
        iot_cmd_t c;
        c.op       = op_e'(raw[F_OP_LO +: 2]);
        c.chk_skip = raw[F_CHK_SKIP];
        c.exp_skip = raw[F_EXP_SKIP];
        c.chk_ac   = raw[F_CHK_AC];
        c.mb       = raw[F_MB_LO +: 12];
        c.ac       = raw[F_AC_LO +: 12];
        c.exp      = raw[F_EXP_LO +: 12];
        return c;
    endfunction

    function automatic logic [11:0] iot_result(input logic        clear_ac,
                                               input logic        data_avail,
                                               input logic [11:0] ac,
                                               input logic [11:0] data);
        return (clear_ac ? 12'o0000 : ac) | (data_avail ? data : 12'o0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdp8_iot_exerciser_if.sv
//------------------------------------------------------------------------------
// Module : pdp8_iot_exerciser_if
// Brief  : IOT bus between a bus master (CPU or exerciser) and pdp8_io.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pdp8_iot_exerciser_if;
    logic        iot;
    logic [3:0]  state;
    logic [11:0] mb;
    logic [11:0] io_ac_out;
    logic [11:0] io_data_in;
    logic        io_data_avail;
    logic        io_skip;
    logic        io_clear_ac;
    logic        io_interrupt;

    modport master (
        output iot, state, mb, io_ac_out,
        input  io_data_in, io_data_avail, io_skip, io_clear_ac, io_interrupt
    );

    modport slave (
        input  iot, state, mb, io_ac_out,
        output io_data_in, io_data_avail, io_skip, io_clear_ac, io_interrupt
    );
endinterface

`default_nettype wire

// File: rtl/pdp8_iot_exerciser_ram.sv
//------------------------------------------------------------------------------
// Module : iot_script_ram
// Brief  : DEPTH x W script store, one write port, one registered read port.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module iot_script_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 44
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [W-1:0]  i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/pdp8_iot_exerciser.sv
//------------------------------------------------------------------------------
// Module : pdp8_iot_exerciser
// Brief  : Scripted IOT bus master: replays a script, captures and checks results.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pdp8_iot_exerciser
    import pdp8_iot_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter int         TIMEOUT = 4095,
    parameter logic [3:0] ST_F0   = C_ST_F0,
    parameter logic [3:0] ST_F1   = C_ST_F1,
    parameter logic [3:0] ST_F2   = C_ST_F2,
    parameter logic [3:0] ST_F3   = C_ST_F3
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               prog_we,
    input  wire logic [AW-1:0]      prog_addr,
    input  wire logic [ENTRY_W-1:0] prog_data,
    input  wire logic               start,
    pdp8_iot_exerciser_if.master    bus,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [AW-1:0]           fail_index,
    output logic [11:0]             last_ac
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_P0       = 4'd2,
        S_P1       = 4'd3,
        S_P2       = 4'd4,
        S_P3       = 4'd5,
        S_WAIT_INT = 4'd6,
        S_WAIT_CYC = 4'd7,
        S_CHECK    = 4'd8,
        S_END      = 4'd9
    } fsm_e;

    localparam logic [AW-1:0] C_LAST_PC  = AW'(DEPTH - 1);
    localparam logic [11:0]   C_TO_LIMIT = 12'(TIMEOUT - 1);

    fsm_e          r_st, w_st_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_fail, w_fail_nxt;
    logic [AW-1:0] r_fidx, w_fidx_nxt;
    logic [11:0]   r_wcnt, w_wcnt_nxt;
    logic          r_skip_s, w_skip_nxt;
    logic [11:0]   r_last_ac, w_last_ac_nxt;

    logic [ENTRY_W-1:0] w_rdata;
    iot_cmd_t           w_cmd;
    logic               w_in_iot;
    logic               w_chk_err;
    logic [3:0]         w_state_code;

    // Read address is the pc of the next cycle, so entry[pc] is already
    // registered by the time FETCH decodes it and stays stable afterwards.
    iot_script_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (prog_we && !r_busy),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_pc_nxt),
        .o_rdata (w_rdata)
    );

    assign w_cmd     = decode_entry(w_rdata);
    assign w_in_iot  = (r_st == S_P0) || (r_st == S_P1) || (r_st == S_P2) || (r_st == S_P3);
    assign w_chk_err = (w_cmd.op == OP_IOT) &&
                       ((w_cmd.chk_skip && (r_skip_s != w_cmd.exp_skip)) ||
                        (w_cmd.chk_ac && (r_last_ac != w_cmd.exp)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st      <= S_IDLE;
            r_pc      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_fidx    <= '0;
            r_wcnt    <= '0;
            r_skip_s  <= 1'b0;
            r_last_ac <= '0;
        end else begin
            r_st      <= w_st_nxt;
            r_pc      <= w_pc_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_fail    <= w_fail_nxt;
            r_fidx    <= w_fidx_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_skip_s  <= w_skip_nxt;
            r_last_ac <= w_last_ac_nxt;
        end
    end

    always_comb begin
        w_st_nxt      = r_st;
        w_pc_nxt      = r_pc;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_fail_nxt    = r_fail;
        w_fidx_nxt    = r_fidx;
        w_wcnt_nxt    = r_wcnt;
        w_skip_nxt    = r_skip_s;
        w_last_ac_nxt = r_last_ac;

        case (r_st)
            S_IDLE, S_END: begin
                if (start) begin
                    w_st_nxt   = S_FETCH;
                    w_pc_nxt   = '0;
                    w_busy_nxt = 1'b1;
                    w_done_nxt = 1'b0;
                    w_fail_nxt = 1'b0;
                    w_fidx_nxt = '0;
                end
            end
            S_FETCH: begin
                w_wcnt_nxt = '0;
                case (w_cmd.op)
                    OP_IOT:      w_st_nxt = S_P0;
                    OP_WAIT_INT: w_st_nxt = S_WAIT_INT;
                    OP_WAIT_CYC: w_st_nxt = S_WAIT_CYC;
                    default: begin
                        w_st_nxt   = S_END;
                        w_done_nxt = 1'b1;
                        w_busy_nxt = 1'b0;
                    end
                endcase
            end
            S_P0: w_st_nxt = S_P1;
            S_P1: w_st_nxt = S_P2;
            S_P2: w_st_nxt = S_P3;
            S_P3: begin
                w_st_nxt      = S_CHECK;
                w_skip_nxt    = bus.io_skip;
                w_last_ac_nxt = iot_result(bus.io_clear_ac, bus.io_data_avail,
                                           w_cmd.ac, bus.io_data_in);
            end
            S_WAIT_INT: begin
                if (bus.io_interrupt) begin
                    w_st_nxt = S_CHECK;
                end else if (r_wcnt == C_TO_LIMIT) begin
                    w_st_nxt   = S_END;
                    w_fail_nxt = 1'b1;
                    w_fidx_nxt = r_pc;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end else begin
                    w_wcnt_nxt = r_wcnt + 12'd1;
                end
            end
            S_WAIT_CYC: begin
                if (r_wcnt == w_cmd.exp) begin
                    w_st_nxt = S_CHECK;
                end else begin
                    w_wcnt_nxt = r_wcnt + 12'd1;
                end
            end
            S_CHECK: begin
                if (w_chk_err) begin
                    w_st_nxt   = S_END;
                    w_fail_nxt = 1'b1;
                    w_fidx_nxt = r_pc;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end else if (r_pc == C_LAST_PC) begin
                    w_st_nxt   = S_END;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end else begin
                    w_st_nxt = S_FETCH;
                    w_pc_nxt = r_pc + AW'(1);
                end
            end
            default: w_st_nxt = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register so an async reset
    // removes them in the same cycle.
    always_comb begin
        w_state_code = 4'h0;
        case (r_st)
            S_P0:    w_state_code = ST_F0;
            S_P1:    w_state_code = ST_F1;
            S_P2:    w_state_code = ST_F2;
            S_P3:    w_state_code = ST_F3;
            default: w_state_code = 4'h0;
        endcase
    end

    assign bus.iot       = w_in_iot;
    assign bus.state     = w_state_code;
    assign bus.mb        = w_in_iot ? w_cmd.mb : 12'o0000;
    assign bus.io_ac_out = w_in_iot ? w_cmd.ac : 12'o0000;

    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign fail_index = r_fidx;
    assign last_ac    = r_last_ac;

endmodule

`default_nettype wire
